// File: rtl/cpu_pkg.sv
// Shared CPU definitions: address-width / reset-vector defaults and the
// program-counter run-control state encoding.
package cpu_pkg;

  localparam int          ADDR_W_DEF    = 24;
  localparam logic [23:0] RESET_VEC_DEF = 24'h000000;

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } run_state_t;

endpackage

// File: rtl/return_stack.sv
// Circular return-address stack. Push when full overwrites the oldest entry;
// pop when empty leaves the stack untouched. Both events raise sticky flags.
module return_stack
  import cpu_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic              pop,
  input  logic [ADDR_W-1:0] data,
  output logic [ADDR_W-1:0] top,
  output logic              full,
  output logic              empty,
  output logic              overflow,
  output logic              underflow
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DEPTH-1:0][ADDR_W-1:0] mem;
  logic [PW-1:0]                ptr;
  logic [PW-1:0]                top_idx;
  logic [PW:0]                  count;

  // ptr always names the next slot to write; once full, that slot is the oldest
  assign top_idx = ptr - PW'(1);
  assign top     = mem[top_idx];
  assign full    = (count == (PW+1)'(DEPTH));
  assign empty   = (count == '0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr       <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (push) begin
      mem[ptr] <= data;
      ptr      <= ptr + PW'(1);
      if (full) overflow <= 1'b1;
      else      count    <= count + (PW+1)'(1);
    end else if (pop) begin
      if (empty) begin
        underflow <= 1'b1;
      end else begin
        ptr   <= top_idx;
        count <= count - (PW+1)'(1);
      end
    end
  end

endmodule

// File: rtl/pc_unit.sv
// Program-counter stage with BOOT/RUN/HALTED run control.
// Define PC_RAS_EN to build the return-address stack for Call/Return.
module pc_unit
  import cpu_pkg::*;
#(
  parameter int                ADDR_W    = ADDR_W_DEF,
  parameter logic [ADDR_W-1:0] RESET_VEC = ADDR_W'(RESET_VEC_DEF),
  parameter int                RAS_DEPTH = 4
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Stall,
  input  logic              Halt,
  input  logic              Jump,
  input  logic              Call,
  input  logic [ADDR_W-1:0] JumpTarget,
  input  logic              Return,
  input  logic              Branch,
  input  logic [ADDR_W-1:0] BranchTarget,
  output logic [ADDR_W-1:0] PC,
  output logic [ADDR_W-1:0] PCPlus1,
  output logic              Running,
  output logic              RasOverflow,
  output logic              RasUnderflow
);

  run_state_t        state, state_nxt;
  logic [ADDR_W-1:0] pc_q, pc_nxt, pc_plus1;

  assign pc_plus1 = pc_q + ADDR_W'(1);
  assign PC       = pc_q;
  assign PCPlus1  = pc_plus1;
  assign Running  = (state == RUN);

`ifdef PC_RAS_EN
  logic              ras_push, ras_pop;
  logic [ADDR_W-1:0] ras_top;
  logic              ras_full, ras_empty;
  logic              unused_full;

  return_stack #(
    .ADDR_W (ADDR_W),
    .DEPTH  (RAS_DEPTH)
  ) u_ras (
    .clk       (Clock),
    .rst_n     (Reset),
    .push      (ras_push),
    .pop       (ras_pop),
    .data      (pc_plus1),
    .top       (ras_top),
    .full      (ras_full),
    .empty     (ras_empty),
    .overflow  (RasOverflow),
    .underflow (RasUnderflow)
  );

  assign unused_full = ras_full;
`else
  localparam int unused_depth = RAS_DEPTH;
  logic unused_return;

  assign unused_return = Return;
  assign RasOverflow   = 1'b0;
  assign RasUnderflow  = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc_q;
`ifdef PC_RAS_EN
    ras_push  = 1'b0;
    ras_pop   = 1'b0;
`endif
    case (state)
      BOOT:    state_nxt = RUN;
      RUN: begin
        if (!Stall) begin
          if (Halt) begin
            state_nxt = HALTED;
          end else if (Jump || Call) begin
            pc_nxt = JumpTarget;
`ifdef PC_RAS_EN
            // Call wins over a simultaneous Return: push only, no pop
            ras_push = Call;
          end else if (Return) begin
            ras_pop = 1'b1;
            pc_nxt  = ras_empty ? pc_plus1 : ras_top;
`endif
          end else if (Branch) begin
            pc_nxt = BranchTarget;
          end else begin
            pc_nxt = pc_plus1;
          end
        end
      end
      HALTED:  state_nxt = HALTED;
      default: state_nxt = BOOT;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state <= BOOT;
      pc_q  <= RESET_VEC;
    end else begin
      state <= state_nxt;
      pc_q  <= pc_nxt;
    end
  end

endmodule

// File: doc/pc_unit.md
# pc_unit

Program-counter stage of the 24-bit single-cycle CPU. Holds the architectural PC and computes the next PC from sequential increment, branch, jump, call and return requests. Its next-PC choice consumes the branch-select decision produced by the 2-to-1 next-address mux stage. Its registered PC output feeds instruction fetch. A small run-control state machine gates fetch at boot and after a halt instruction.

## Interface
Parameters:
- ADDR_W, 24, PC / address width
- RESET_VEC, 24'h000000, PC value loaded by reset
- RAS_DEPTH, 4, return-address-stack entries (power of two, ≥2; used only with PC_RAS_EN)

Ports:
- Clock  in  1  rising-edge clock
- Reset  in  1  synchronous, active-low reset
- Stall  in  1  hold PC, state and stack this cycle
- Halt  in  1  halt instruction decoded
- Jump  in  1  unconditional jump to JumpTarget
- Call  in  1  jump to JumpTarget and push PC+1
- JumpTarget  in  ADDR_W  jump/call destination
- Return  in  1  jump to popped return address
- Branch  in  1  branch taken (mux select)
- BranchTarget  in  ADDR_W  branch destination
- PC  out  ADDR_W  current PC (registered)
- PCPlus1  out  ADDR_W  PC+1 mod 2^ADDR_W (combinational from PC)
- Running  out  1  state is RUN; fetch valid
- RasOverflow  out  1  sticky: push occurred while stack full
- RasUnderflow  out  1  sticky: pop occurred while stack empty

## Operation
- States: BOOT, RUN, HALTED.
- Reset low at a clock edge: PC=RESET_VEC, state=BOOT, stack emptied, both flags=0, Running=0. Reset overrides every other input, including mid-halt and mid-stall.
- BOOT: PC held for one cycle, then →RUN unconditionally (Stall ignored in BOOT).
- RUN, Stall=1: PC, state, stack and flags unchanged.
- RUN, Stall=0, priority high→low:
  - Halt: PC unchanged, →HALTED.
  - Jump or Call: PC=JumpTarget; Call also pushes PCPlus1.
  - Return: PC=popped entry.
  - Branch: PC=BranchTarget.
  - Otherwise: PC=PCPlus1.
- Lower-priority requests asserted together with a winner are dropped with no side effect. Call+Return in the same cycle: push only, no pop.
- HALTED: PC frozen, all requests ignored; exit only via reset.
- Increment wraps: PC=24'hFFFFFF → 24'h000000. No flag is raised.
- Stack push when full overwrites the oldest entry (circular) and sets RasOverflow.
- Pop when empty yields PCPlus1 as the target, leaves the stack empty, and sets RasUnderflow.

## Timing
- All state updates on the rising edge. PC reflects a redirect one cycle after the request is sampled.
- Targets are sampled in the same cycle as their request. No request is ever latched across cycles.
- Running deasserts the cycle after Halt is sampled.
- Running asserts exactly one cycle after Reset goes high.
- Flags set in the cycle after the offending push/pop and hold until reset.

## Configuration
- PC_RAS_EN defined: return-address stack of RAS_DEPTH entries built as specified.
- PC_RAS_EN undefined: no stack.
  - Call behaves exactly as Jump (no push).
  - Return is ignored; the cycle takes the Branch or sequential path.
  - RasOverflow and RasUnderflow are tied 0.

## Structure
- Shared package cpu_pkg holds:
  - the ADDR_W default
  - the RESET_VEC default
  - the run-state enum (BOOT, RUN, HALTED)
- Sub-module return_stack provides:
  - push, pop, full, empty
  - top data
  - circular pointer and count
  - It is instantiated only under PC_RAS_EN.

## Test plan
- Reset, then release; Stall=0 → PC=000000 for 2 cycles (BOOT, then first RUN cycle), then 000001, 000002; Running rises 1 cycle after release.
- PC=000010, Branch=1, BranchTarget=000100 together with Jump=1, JumpTarget=000200 → next PC=000200; Stall=1 the following cycle → PC holds 000200.
- Wrap case: Jump to FFFFFF, then sequential → PC=000000.
- Halt at PC=000020 with Branch=1 → PC stays 000020, Running=0 next cycle, later requests ignored. Reset low → PC=000000, state BOOT.
- PC_RAS_EN: from PC=000030, Call to 000100 → PC=000100; Return → PC=000031. Return on empty stack at PC=000040 → PC=000041, RasUnderflow=1.
- PC_RAS_EN, RAS_DEPTH=4: five nested Calls → RasOverflow=1. Five Returns → four correct addresses (innermost first), and the fifth sets RasUnderflow.
